// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and width helper.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bits needed to count WIDTH iterations (0..WIDTH-1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple-carry adder built from full_adder cells, with carry-in and carry-out.
module adder_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple-carry arithmetic blocks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one WIDTH-bit adder iterated WIDTH times per product.
// Optional two's-complement mode enabled by defining SHIFT_ADD_MULT_SIGNED_EN.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    logic               accept;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     hi_next;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic [2*WIDTH-1:0] result;

    assign accept = start && ((state == IDLE) || (state == DONE));

    adder_nbit #(.WIDTH(WIDTH)) u_acc_add (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Conditional add into the upper half, then shift {carry, acc, mplier} right one bit.
    assign hi_next     = mplier[0] ? {add_cout, add_sum} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign acc_next    = {hi_next, acc[WIDTH-1:1]};
    assign mplier_next = {acc[0], mplier[WIDTH-1:1]};

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic               neg_flag;
    logic [2*WIDTH-1:0] neg_sum;
    logic               neg_cout_unused;

    // Magnitudes are loaded; the most negative value maps to 2^(WIDTH-1).
    assign load_a = (signed_mode && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
    assign load_b = (signed_mode && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;

    adder_nbit #(.WIDTH(2*WIDTH)) u_neg_add (
        .a    (~acc),
        .b    ('0),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_cout_unused)
    );

    assign result = neg_flag ? neg_sum : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_flag <= 1'b0;
        end else if (accept) begin
            neg_flag <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end
`else
    assign load_a = a;
    assign load_b = b;
    assign result = acc;
`endif

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            done <= 1'b0;
            if (state == DONE) begin
                p    <= result;
                done <= 1'b1;
            end
            if (accept) begin
                mcand  <= load_a;
                mplier <= load_b;
                acc    <= '0;
                count  <= '0;
                busy   <= 1'b1;
                state  <= CALC;
            end else begin
                case (state)
                    IDLE: ;
                    CALC: begin
                        acc    <= acc_next;
                        mplier <= mplier_next;
                        count  <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at WIDTH=4 and WIDTH=8 (signed mode under SHIFT_ADD_MULT_SIGNED_EN).
module tb_shift_add_multiplier;

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic        sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done4_n = 0;
    int   done8_n = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t m4, m8;

    shift_add_multiplier #(.WIDTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        .signed_mode (sm4),
`endif
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic sm8 = 1'b0;
`endif

    shift_add_multiplier #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        .signed_mode (sm8),
`endif
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop expected product and due cycle whenever a done pulse appears.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            done4_n++;
            if (q4.size() == 0) begin
                check("unexpected_done4", 64'(done4), 64'd0);
            end else begin
                m4 = q4.pop_front();
                check("p4", 64'(p4), 64'(m4.p));
                check("latency4", 64'(cyc), 64'(m4.due));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            done8_n++;
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(done8), 64'd0);
            end else begin
                m8 = q8.pop_front();
                check("p8", 64'(p8), 64'(m8.p));
                check("latency8", 64'(cyc), 64'(m8.due));
            end
        end
    end

    // Issue one operation (called at negedge+1) and return in the cycle its done is seen.
    task automatic op(input int w, input logic [7:0] ta, input logic [7:0] tb2,
                      input logic sm, input bit poke);
        int   pa, pb, prev, n;
        exp_t x;
        pa = int'(ta);
        pb = int'(tb2);
        if (sm && w == 4) begin
            if (ta[3])  pa -= 16;
            if (tb2[3]) pb -= 16;
        end
        x.p   = (w == 4) ? 16'(32'(pa * pb) & 32'hff) : 16'(pa * pb);
        x.due = cyc + w + 2;
        if (w == 4) begin
            a4 = 4'(ta); b4 = 4'(tb2); sm4 = sm; start4 = 1'b1;
            q4.push_back(x);
            prev = done4_n;
        end else begin
            a8 = ta; b8 = tb2; start8 = 1'b1;
            q8.push_back(x);
            prev = done8_n;
        end
        @(posedge clk);
        @(negedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        check("busy_after_start", 64'((w == 4) ? busy4 : busy8), 64'd1);
        if (poke) begin
            a4 = 4'hf; b4 = 4'hf; start4 = 1'b1;
            @(negedge clk); #1;
            start4 = 1'b0;
        end
        n = 0;
        while ((((w == 4) ? done4_n : done8_n) == prev) && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 40) check("done_timeout", 64'(n), 64'd0);
    endtask

    task automatic reset_mid_calc();
        int c, prev;
        prev = done4_n;
        c = cyc;
        a4 = 4'd9; b4 = 4'd7; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        start4 = 1'b0;
        while (cyc < c + 3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_p", 64'(p4), 64'd0);
        check("rst_busy", 64'(busy4), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("no_done_after_rst", 64'(done4_n), 64'(prev));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_p4", 64'(p4), 64'd0);
        check("reset_busy4", 64'(busy4), 64'd0);
        check("reset_done4", 64'(done4), 64'd0);
        check("reset_p8", 64'(p8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        op(4, 8'd13, 8'd11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("hold_p", 64'(p4), 64'd143);
        check("hold_busy", 64'(busy4), 64'd0);
        check("hold_done", 64'(done4), 64'd0);

        op(4, 8'd5, 8'd3, 1'b0, 1'b1);
        reset_mid_calc();
        op(4, 8'd2, 8'd6, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                op(4, 8'(i), 8'(j), 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            op(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
`else
            op(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b0, 1'b0);
`endif
        end

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        op(4, 8'hd, 8'h5, 1'b1, 1'b0);
        op(4, 8'h8, 8'h8, 1'b1, 1'b0);
        op(4, 8'h8, 8'h7, 1'b1, 1'b0);
        op(4, 8'hd, 8'h5, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        #1;
        op(8, 8'd255, 8'd255, 1'b0, 1'b0);
        op(8, 8'd0, 8'd200, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++)
            op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        #1;
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Parametrised sequential unsigned multiplier, the multi-cycle successor to the combinational 4-bit array multiplier.
- One WIDTH-bit adder iterated over WIDTH cycles, with a start/busy/done handshake.
- Used where area matters more than latency; same gate-level adder style as the existing arithmetic blocks.
- Result is held stable until the next accepted start.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  multiplicand, captured on accepted start
b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when p becomes valid
p  output  2*WIDTH  product; held until the next accepted start

Behaviour:
- Reset, asynchronous, rst_n low:
  - state=IDLE; busy=0, done=0, p=0; all internal registers (acc, mcand, mplier, count) cleared.
- States: IDLE, CALC, DONE.
- Start acceptance:
  - Accepted when start=1 in IDLE or DONE.
  - On the accepting edge: mcand<=a, mplier<=b, acc<=0, count<=0; go to CALC.
  - busy=1 from the following cycle.
- CALC, one iteration per cycle:
  - If mplier[0]=1, add mcand to acc[2W-1:W] using a (W+1)-bit sum.
  - Then shift {carry, acc, mplier} right by 1.
  - count increments.
  - After WIDTH iterations (count==WIDTH-1 on the last one), go to DONE.
- DONE:
  - p <= final acc; done=1 for exactly this cycle; busy=0.
  - Next state is IDLE, or CALC if start=1.
- Latency: start accepted at edge N -> done high and p valid in the cycle after edge N+WIDTH+1.
  - WIDTH=4: done in the 6th cycle after the start edge.
- start while busy (CALC): ignored; no queuing; operands unaffected.
- a/b changing after acceptance: no effect.
- p changes only on the DONE transition; otherwise held, including across IDLE.
- Operands of 0: full WIDTH iterations still run (no early exit); p=0.
- rst_n asserted mid-CALC: operation abandoned; p=0; no done pulse.
- Arithmetic: exact unsigned product, no overflow possible (2W-bit result).

Optional Feature:
Macro SHIFT_ADD_MULT_SIGNED_EN.
- Defined:
  - Extra input port signed_mode (1 bit), captured with a/b on start.
  - signed_mode=1: a and b are treated as two's complement. Their magnitudes are loaded (-2^(W-1) maps to magnitude 2^(W-1)), and the sign flag is the XOR of the operand MSBs.
  - In DONE, p = negated acc if the sign flag is set; latency is unchanged.
  - signed_mode=0: identical to the unsigned behaviour.
- Undefined: no signed_mode port; unsigned only.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Width helper constant: count width = clog2(WIDTH).
- One sub-module: adder_nbit, a WIDTH-parametrised ripple-carry adder built from the team's Full_Adder cell, exposing carry-out.
  - Instantiated once for the accumulate step.
  - The signed negation reuses a second instance (~acc + 1).

Test Plan:
- WIDTH=4, a=13, b=11, start pulse -> busy=1 next cycle; done=1 in the 6th cycle; p=8'd143; p still 143 three cycles later.
- WIDTH=4, exhaustive 16x16 operand sweep back-to-back, with start asserted in the DONE cycle -> every p equals a*b, no idle gap, one done per operation.
- WIDTH=4, a=5, b=3; start re-asserted with a=15, b=15 during CALC -> ignored; p=15, not 225.
- WIDTH=4, a=9, b=7; rst_n low for 1 cycle at the 3rd CALC cycle -> p=0, busy=0, no done; next start with a=2, b=6 -> p=12.
- WIDTH=8, a=255, b=255 -> p=16'd65025 with done in the 10th cycle; a=0, b=200 -> p=0 at the same latency.
- SHIFT_ADD_MULT_SIGNED_EN, WIDTH=4, signed_mode=1:
  - -3*5 -> p=8'hF1
  - -8*-8 -> p=8'h40
  - -8*7 -> p=8'hC8
  - signed_mode=0 with 4'hD*4'h5 -> p=8'h41
